// File: rtl/mul7_sched_pkg.sv
// Shared definitions for the MUL7 request scheduler.
//   sched_state_t : scheduler FSM states
//   MUL7_DATA_W   : operand width of the MUL7 serial detector
//   id_width()    : width of a requester index for n requesters
package mul7_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        ISSUE,
        WAIT,
        RESP
    } sched_state_t;

    localparam int MUL7_DATA_W = 32;

    // A single requester still needs a 1-bit index field.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mul7_scheduler_rr_arbiter.sv
// Round-robin arbiter for the MUL7 scheduler.
//   req      in  N     : pending requests
//   last_id  in  ID_W  : most recently granted requester
//   en       in  1     : arbitration enable; grant is zero when low
//   grant    out N     : one-hot grant (zero when nothing is pending)
//   grant_id out ID_W  : index of the granted requester
module rr_arbiter
    import mul7_sched_pkg::*;
#(
    parameter int N = 4,
    localparam int ID_W = id_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last_id,
    input  logic            en,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id
);

    logic            w_found;
    logic [ID_W-1:0] w_idx;

    // Search starts one past the last winner and wraps, so the previous
    // winner is the last candidate considered.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        grant    = '0;
        grant_id = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = ID_W'((int'(last_id) + k) % N);
            if (en && !w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                grant_id     = w_idx;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul7_scheduler.sv
// Shares one serial multiple-of-7 detector (MUL7) between N requesters.
// Each job: round-robin grant, one-cycle MUL7 reset, operand issue, wait for
// the result (or watchdog abort), one-cycle response to the owner.
//   clk, rst        : clock, synchronous active-high reset
//   req_valid/data  : per-requester job request and operand
//   req_ready       : one-hot grant, only in IDLE
//   resp_valid      : one-hot, one-cycle completion pulse to the owner
//   resp_res        : 1 = operand is a multiple of 7
//   resp_timeout    : job aborted by the watchdog (resp_res forced to 0)
//   resp_id         : owner index
//   busy            : high outside IDLE
//   m_rst/m_src/m_src_valid : drive MUL7
//   m_ready/m_res/m_res_valid : from MUL7
module mul7_scheduler
    import mul7_sched_pkg::*;
#(
    parameter int N       = 4,
    parameter int DATA_W  = MUL7_DATA_W,
    parameter int TIMEOUT = 64,
    localparam int ID_W   = id_width(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req_valid,
    input  logic [N*DATA_W-1:0] req_data,
    output logic [N-1:0]        req_ready,
    output logic [N-1:0]        resp_valid,
    output logic                resp_res,
    output logic                resp_timeout,
    output logic [ID_W-1:0]     resp_id,
    output logic                busy,
    output logic                m_rst,
    output logic [DATA_W-1:0]   m_src,
    output logic                m_src_valid,
    input  logic                m_ready,
    input  logic                m_res,
    input  logic                m_res_valid
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT - 1);

    sched_state_t        r_state;
    sched_state_t        w_next;
    logic [ID_W-1:0]     r_last_id;
    logic [ID_W-1:0]     r_id;
    logic [DATA_W-1:0]   r_m_src;
    logic [CNT_W-1:0]    r_wd_cnt;
    logic [N-1:0]        r_resp_valid;
    logic                r_resp_res;
    logic                r_resp_timeout;
    logic [ID_W-1:0]     r_resp_id;

    logic [N-1:0]        w_grant;
    logic [ID_W-1:0]     w_grant_id;
    logic                w_arb_en;
    logic                w_hs;
    logic                w_wd_expired;

    // Grants are offered only in IDLE and never while reset is asserted.
    assign w_arb_en     = (r_state == IDLE) && !rst;
    assign w_hs         = |(req_valid & w_grant);
    assign w_wd_expired = (r_wd_cnt == WD_LIMIT);

    rr_arbiter #(.N(N)) u_arb (
        .req      (req_valid),
        .last_id  (r_last_id),
        .en       (w_arb_en),
        .grant    (w_grant),
        .grant_id (w_grant_id)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next state and state-decoded outputs.
    always_comb begin
        w_next      = r_state;
        req_ready   = w_grant;
        m_rst       = rst || (r_state == CLR);
        m_src_valid = (r_state == ISSUE);
        busy        = (r_state != IDLE);
        case (r_state)
            IDLE:    if (w_hs) w_next = CLR;
            CLR:     w_next = ISSUE;
            ISSUE:   if (m_ready) w_next = WAIT;
            // A result arriving on the watchdog's last cycle still wins.
            WAIT:    if (m_res_valid || w_wd_expired) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand/ID latch, watchdog counter and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_id      <= ID_W'(N - 1);
            r_id           <= '0;
            r_m_src        <= '0;
            r_wd_cnt       <= '0;
            r_resp_valid   <= '0;
            r_resp_res     <= 1'b0;
            r_resp_timeout <= 1'b0;
            r_resp_id      <= '0;
        end else begin
            r_resp_valid <= '0;
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_id      <= w_grant_id;
                        r_last_id <= w_grant_id;
                        r_m_src   <= req_data[int'(w_grant_id) * DATA_W +: DATA_W];
                    end
                end
                ISSUE: begin
                    if (m_ready) r_wd_cnt <= '0;
                end
                WAIT: begin
                    if (m_res_valid) begin
                        r_resp_valid   <= N'(1) << r_id;
                        r_resp_res     <= m_res;
                        r_resp_timeout <= 1'b0;
                        r_resp_id      <= r_id;
                    end else if (w_wd_expired) begin
                        r_resp_valid   <= N'(1) << r_id;
                        r_resp_res     <= 1'b0;
                        r_resp_timeout <= 1'b1;
                        r_resp_id      <= r_id;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_src        = r_m_src;
    assign resp_valid   = r_resp_valid;
    assign resp_res     = r_resp_res;
    assign resp_timeout = r_resp_timeout;
    assign resp_id      = r_resp_id;

endmodule

// File: tb/tb_mul7_scheduler.sv
// Self-checking bench for mul7_scheduler with a behavioural MUL7 stand-in
// whose ready stall, latency and hang behaviour are set per job.
module tb_mul7_scheduler;

    localparam int N       = 4;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 64;
    localparam int ID_W    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [N-1:0]        req_valid;
    logic [N*DATA_W-1:0] req_data;
    logic [N-1:0]        req_ready;
    logic [N-1:0]        resp_valid;
    logic                resp_res;
    logic                resp_timeout;
    logic [ID_W-1:0]     resp_id;
    logic                busy;
    logic                m_rst;
    logic [DATA_W-1:0]   m_src;
    logic                m_src_valid;
    logic                m_ready;
    logic                m_res;
    logic                m_res_valid;

    logic [DATA_W-1:0] ops [N];

    for (genvar g = 0; g < N; g++) begin : g_data
        assign req_data[g*DATA_W +: DATA_W] = ops[g];
    end

    mul7_scheduler #(.N(N), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_res     (resp_res),
        .resp_timeout (resp_timeout),
        .resp_id      (resp_id),
        .busy         (busy),
        .m_rst        (m_rst),
        .m_src        (m_src),
        .m_src_valid  (m_src_valid),
        .m_ready      (m_ready),
        .m_res        (m_res),
        .m_res_valid  (m_res_valid)
    );

    // ---------------- behavioural MUL7 ----------------
    // Accepts one operand per reset; holds ready low for cfg_stall cycles
    // after reset; raises res_valid cfg_lat cycles after WAIT entry.
    int          cfg_stall = 0;
    int          cfg_lat   = 1;
    bit          cfg_hang  = 1'b0;
    bit          mm_armed  = 1'b0;
    bit          mm_comp   = 1'b0;
    int          mm_stall  = 0;
    int          mm_lat    = 0;
    logic [31:0] mm_op     = '0;
    logic        mm_res    = 1'b0;
    logic        mm_res_valid = 1'b0;

    assign m_ready     = mm_armed && (mm_stall == 0);
    assign m_res       = mm_res;
    assign m_res_valid = mm_res_valid;

    always @(posedge clk) begin
        mm_res_valid <= 1'b0;
        if (m_rst) begin
            mm_armed <= 1'b1;
            mm_comp  <= 1'b0;
            mm_stall <= cfg_stall;
        end else if (mm_armed) begin
            if (mm_stall > 0) mm_stall <= mm_stall - 1;
            else if (m_src_valid) begin
                mm_armed <= 1'b0;
                mm_comp  <= 1'b1;
                mm_lat   <= cfg_lat;
                mm_op    <= m_src;
            end
        end else if (mm_comp) begin
            if (mm_lat > 1) mm_lat <= mm_lat - 1;
            else if (!cfg_hang) begin
                mm_res_valid <= 1'b1;
                mm_res       <= (mm_op % 7 == 0);
                mm_comp      <= 1'b0;
            end
        end
    end

    // ---------------- monitors ----------------
    int          cyc = 0;
    int          mrst_cnt = 0, resp_cnt = 0, src_bad = 0, stall_seen = 0;
    logic [31:0] mon_op = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_rst) mrst_cnt <= mrst_cnt + 1;
        if (resp_valid != '0) resp_cnt <= resp_cnt + 1;
        if (m_src_valid) begin
            if (m_src !== mon_op) src_bad <= src_bad + 1;
            if (!m_ready) stall_seen <= stall_seen + 1;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int m_last   = N - 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [N-1:0] mask);
        for (int k = 1; k <= N; k++)
            if (mask[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_last = N - 1;
    endtask

    task automatic wait_grant(input string tag, input int exp_id, output int t_hs);
        logic [N-1:0] g, e;
        g = '0;
        e = '0;
        e[exp_id] = 1'b1;
        t_hs = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                g    = req_ready;
                t_hs = cyc;
                break;
            end
        end
        check({tag, "_grant"}, 64'(g), 64'(e));
        @(posedge clk);
        #1 req_valid = req_valid & ~g;
    endtask

    // One job from grant to response. Expected response cycle follows the
    // job timeline: handshake t, CLR t+1, ISSUE from t+2 (S stall cycles),
    // WAIT from t+3+S, result L cycles into WAIT, RESP one cycle later;
    // or abort exactly TIMEOUT cycles after WAIT entry.
    task automatic do_job(input string tag, input int exp_id, input bit exp_res,
                          input int s, input int l, input bit hang,
                          input int exp_hs, output int t_resp);
        int t_hs, exp_cycle, mrst0, stall0, bad0;
        bit to;
        logic [N-1:0] e;
        bit seen;
        cfg_stall = s;
        cfg_lat   = l;
        cfg_hang  = hang;
        mon_op    = ops[exp_id];
        wait_grant(tag, exp_id, t_hs);
        if (exp_hs >= 0) check({tag, "_hs_cycle"}, 64'(t_hs), 64'(exp_hs));
        check({tag, "_busy"}, 64'(busy), 64'(1));
        m_last = exp_id;
        mrst0  = mrst_cnt;
        stall0 = stall_seen;
        bad0   = src_bad;
        to        = hang || (l > TIMEOUT - 1);
        exp_cycle = to ? t_hs + 3 + s + TIMEOUT : t_hs + 4 + s + l;
        e = '0;
        e[exp_id] = 1'b1;
        seen = 1'b0;
        t_resp = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (resp_valid != '0) begin
                seen   = 1'b1;
                t_resp = cyc;
                break;
            end
        end
        check({tag, "_resp_seen"}, 64'(seen), 64'(1));
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'(e));
        check({tag, "_resp_id"}, 64'(resp_id), 64'(exp_id));
        check({tag, "_resp_res"}, 64'(resp_res), 64'(to ? 1'b0 : exp_res));
        check({tag, "_resp_timeout"}, 64'(resp_timeout), 64'(to));
        check({tag, "_resp_cycle"}, 64'(t_resp), 64'(exp_cycle));
        check({tag, "_mrst_pulses"}, 64'(mrst_cnt - mrst0), 64'(1));
        check({tag, "_stall_cycles"}, 64'(stall_seen - stall0), 64'(s));
        check({tag, "_src_stable"}, 64'(src_bad - bad0), 64'(0));
    endtask

    typedef struct {
        logic [31:0] op;
        bit          exp_res;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        vec_t dir_vecs [7];
        bit   cont_res [4];
        int   fair_ids [4];
        int   t_prev, t_r, exp_id, resp0;
        logic [N-1:0] newbits;

        dir_vecs[0] = '{32'd7,   1'b1};
        dir_vecs[1] = '{32'd14,  1'b1};
        dir_vecs[2] = '{32'd15,  1'b0};
        dir_vecs[3] = '{32'd896, 1'b1};
        dir_vecs[4] = '{32'd0,   1'b1};
        dir_vecs[5] = '{32'd1,   1'b0};
        dir_vecs[6] = '{32'd165, 1'b0};
        cont_res = '{1'b1, 1'b0, 1'b1, 1'b0};
        fair_ids = '{1, 3, 1, 3};

        for (int i = 0; i < N; i++) ops[i] = '0;
        rst       = 1'b1;
        req_valid = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_rst", 64'(m_rst), 64'(1));
        check("rst_req_ready", 64'(req_ready), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        req_valid = '0;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_resp_valid", 64'(resp_valid), 64'(0));
        check("rst_m_src", 64'(m_src), 64'(0));
        check("rst_m_src_valid", 64'(m_src_valid), 64'(0));
        check("rst_resp_id", 64'(resp_id), 64'(0));
        check("rst_m_rst_low", 64'(m_rst), 64'(0));

        // Directed results from requester 0.
        for (int i = 0; i < 7; i++) begin
            ops[0] = dir_vecs[i].op;
            req_valid[0] = 1'b1;
            do_job("dir", 0, dir_vecs[i].exp_res, 0, 3, 1'b0, -1, t_r);
        end

        // Watchdog boundaries: result on the last WAIT cycle wins, one
        // cycle later aborts; a hung MUL7 aborts; next job still served.
        ops[0] = 32'd14; req_valid[0] = 1'b1;
        do_job("wd_edge_res", 0, 1'b1, 0, TIMEOUT - 1, 1'b0, -1, t_r);
        ops[0] = 32'd14; req_valid[0] = 1'b1;
        do_job("wd_edge_to", 0, 1'b1, 0, TIMEOUT, 1'b0, -1, t_r);
        ops[0] = 32'd21; req_valid[0] = 1'b1;
        do_job("wd_hang", 0, 1'b1, 2, 1, 1'b1, -1, t_r);
        ops[0] = 32'd21; req_valid[0] = 1'b1;
        do_job("wd_after", 0, 1'b1, 0, 2, 1'b0, -1, t_r);

        // ISSUE stall of 5 cycles.
        ops[2] = 32'd35; req_valid[2] = 1'b1;
        do_job("stall", 2, 1'b1, 5, 2, 1'b0, -1, t_r);

        // Contention from a fresh reset: grants 0..3 back to back.
        do_reset();
        ops[0] = 32'd7; ops[1] = 32'd8; ops[2] = 32'd21; ops[3] = 32'd22;
        req_valid = '1;
        t_prev = -1;
        for (int i = 0; i < 4; i++) begin
            do_job("cont", i, cont_res[i], 0, 2, 1'b0, (t_prev < 0) ? -1 : t_prev + 1, t_r);
            t_prev = t_r;
        end

        // Fairness: requesters 1 and 3 re-request continuously.
        ops[1] = 32'd49; ops[3] = 32'd50;
        req_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            do_job("fair", fair_ids[i], (ops[fair_ids[i]] % 7 == 0), 0, 1, 1'b0, -1, t_r);
            req_valid[fair_ids[i]] = 1'b1;
        end
        req_valid = '0;
        @(negedge clk);

        // Reset in the middle of WAIT.
        cfg_hang = 1'b1; cfg_stall = 0; cfg_lat = 1;
        ops[2] = 32'd7; mon_op = 32'd7;
        req_valid = 4'b0100;
        exp_id = rr_pick(m_last, req_valid);
        wait_grant("rstwait", exp_id, t_r);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        resp0 = resp_cnt;
        @(negedge clk);
        check("rstwait_m_rst", 64'(m_rst), 64'(1));
        @(posedge clk);
        #1 rst = 1'b0;
        m_last = N - 1;
        @(negedge clk);
        check("rstwait_busy", 64'(busy), 64'(0));
        check("rstwait_resp_valid", 64'(resp_valid), 64'(0));
        check("rstwait_resp_res", 64'(resp_res), 64'(0));
        check("rstwait_resp_timeout", 64'(resp_timeout), 64'(0));
        check("rstwait_resp_id", 64'(resp_id), 64'(0));
        check("rstwait_m_src", 64'(m_src), 64'(0));
        check("rstwait_m_src_valid", 64'(m_src_valid), 64'(0));
        check("rstwait_req_ready", 64'(req_ready), 64'(0));
        repeat (TIMEOUT + 10) @(negedge clk);
        check("rstwait_no_resp", 64'(resp_cnt - resp0), 64'(0));
        ops[0] = 32'd7; req_valid[0] = 1'b1;
        do_job("rstwait_after", 0, 1'b1, 0, 2, 1'b0, -1, t_r);

        // Randomized traffic against the round-robin / mod-7 reference.
        for (int r = 0; r < 25; r++) begin
            newbits = N'($urandom_range(0, (1 << N) - 1)) & ~req_valid;
            if ((req_valid | newbits) == '0) newbits[$urandom_range(0, N - 1)] = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (newbits[i])
                    ops[i] = ($urandom_range(0, 1) == 1) ? 32'(7 * $urandom_range(0, 600000000)) : $urandom;
            end
            req_valid = req_valid | newbits;
            exp_id = rr_pick(m_last, req_valid);
            do_job("rand", exp_id, (ops[exp_id] % 7 == 0),
                   $urandom_range(0, 3), $urandom_range(1, 10), 1'b0, -1, t_r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
